// File: rtl/posit_encode_8_es3_if.sv
// posit_encode_8_es3_if: handshake bundle between the raw ES3 adder, the posit encoder and its consumer.
// Signals: in_sum {sgn, scale[8:0], fraction[28:0], inf, zero}, in_truncated, in_valid, in_ready,
//          out_posit, out_valid, out_ready, plus out_inexact when POSIT_ENC_INEXACT_EN is defined.
// Modports: master = producer/consumer side, slave = encoder side.
interface posit_encode_8_es3_if;
   logic [40:0] in_sum;
   logic        in_truncated;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_posit;
   logic        out_valid;
   logic        out_ready;
`ifdef POSIT_ENC_INEXACT_EN
   logic        out_inexact;
   modport master (output in_sum, in_truncated, in_valid, out_ready,
                   input in_ready, out_posit, out_valid, out_inexact);
   modport slave (input in_sum, in_truncated, in_valid, out_ready,
                  output in_ready, out_posit, out_valid, out_inexact);
`else
   modport master (output in_sum, in_truncated, in_valid, out_ready,
                   input in_ready, out_posit, out_valid);
   modport slave (input in_sum, in_truncated, in_valid, out_ready,
                  output in_ready, out_posit, out_valid);
`endif
endinterface

// File: rtl/posit_encode_8_es3.sv
// posit_encode_8_es3: rounds the raw ES3 adder sum into an 8-bit posit (es=3) over a 3-stage pipeline.
// Ports: clk; rst_n (asynchronous, active-low); bus (posit_encode_8_es3_if.slave):
//        in_sum/in_truncated/in_valid/out_ready in, in_ready/out_posit/out_valid out.
// Option: POSIT_ENC_INEXACT_EN adds bus.out_inexact (guard|sticky or clamp of the emitted item).
module posit_encode_8_es3 (
   input logic                 clk,
   input logic                 rst_n,
   posit_encode_8_es3_if.slave bus
);
   logic              adv;
   logic              s1_v, s1_trunc;
   logic [40:0]       s1_sum;
   logic signed [8:0] s1_scale;
   logic              s2_v, s2_sgn, s2_nar, s2_zero, s2_hi, s2_lo, s2_trunc;
   logic [3:0]        s2_k;
   logic [2:0]        s2_e, sh;
   logic [28:0]       s2_frac;
   logic              fill, guard, sticky, up;
   logic [39:0]       bits;
   logic [7:0]        rnd, posit, o_p;
   logic [6:0]        mag;
   logic              o_v;
   assign adv           = ~o_v | bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = o_v;
   assign bus.out_posit = o_p;
   assign s1_scale      = s1_sum[39:31];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_v     <= 1'b0;
         s1_sum   <= '0;
         s1_trunc <= 1'b0;
         s2_v     <= 1'b0;
         s2_sgn   <= 1'b0;
         s2_nar   <= 1'b0;
         s2_zero  <= 1'b0;
         s2_hi    <= 1'b0;
         s2_lo    <= 1'b0;
         s2_k     <= '0;
         s2_e     <= '0;
         s2_frac  <= '0;
         s2_trunc <= 1'b0;
         o_v      <= 1'b0;
         o_p      <= 8'h00;
      end else if (adv) begin
         s1_v     <= bus.in_valid;
         s1_sum   <= bus.in_sum;
         s1_trunc <= bus.in_truncated;
         s2_v     <= s1_v;
         s2_sgn   <= s1_sum[40];
         s2_nar   <= s1_sum[1];
         s2_zero  <= s1_sum[0];
         s2_hi    <= s1_scale > 9'sd48;
         s2_lo    <= s1_scale < -9'sd48;
         s2_k     <= 4'(s1_scale >>> 3);
         s2_e     <= s1_sum[33:31];
         s2_frac  <= s1_sum[30:2];
         s2_trunc <= s1_trunc;
         o_v      <= s2_v;
         o_p      <= posit;
      end
   // Regime run of 'fill' bits, length k+1 (k>=0) or -k (k<0), is placed by pre-filling 7 copies
   // and shifting the surplus out the top; 3-bit wraparound gives 7+k for negative k.
   always_comb begin
      fill   = ~s2_k[3];
      sh     = fill ? 3'd6 - s2_k[2:0] : 3'd7 + s2_k[2:0];
      bits   = {{7{fill}}, ~fill, s2_e, s2_frac} << sh;
      guard  = bits[32];
      sticky = |bits[31:0] | s2_trunc;
      up     = guard & (sticky | bits[33]);
      rnd    = {1'b0, bits[39:33]} + {7'd0, up};
      mag    = s2_hi ? 7'h7F : s2_lo ? 7'h01 : rnd[7] ? 7'h7F : rnd[6:0] == 7'd0 ? 7'h01 : rnd[6:0];
      posit  = s2_nar ? 8'h80 : s2_zero ? 8'h00 : s2_sgn ? 8'(~{1'b0, mag} + 8'd1) : {1'b0, mag};
   end
`ifdef POSIT_ENC_INEXACT_EN
   logic o_x;
   assign bus.out_inexact = o_x;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) o_x <= 1'b0;
      else if (adv) o_x <= ~s2_nar & ~s2_zero & (s2_hi | s2_lo | guard | sticky);
`endif
endmodule

// File: tb/tb_posit_encode_8_es3.sv
// tb_posit_encode_8_es3: directed self-checking bench for the ES3 posit encoder.
module tb_posit_encode_8_es3;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   posit_encode_8_es3_if bus ();
   posit_encode_8_es3 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [40:0] mk(input logic sg, input int sc, input logic [28:0] fr,
                                      input logic inf, input logic zero);
      logic [8:0] s9;
      s9 = 9'(sc);
      return {sg, s9, fr, inf, zero};
   endfunction

   // one item through an otherwise idle pipeline; lat counts falling edges from the accept edge
   task automatic xfer(input logic [40:0] s, input logic t, output logic [7:0] p, output int lat);
      p = 8'hxx;
      lat = 0;
      @(posedge clk); #1;
      bus.in_sum = s; bus.in_truncated = t; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            p = bus.out_posit;
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_truncated = 1'b0; bus.out_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      n_chk++;
      if (bus.out_posit !== 8'h00) begin n_fail++; $display("FAIL reset_out_posit got %h exp 00", bus.out_posit); end
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
   endtask

   task automatic test_vectors;
      logic [40:0] vs [19];
      logic        vt [19];
      logic [7:0]  ve [19];
      logic [7:0]  p;
      int          lat;
      vs = '{mk(0, 0, 0, 0, 0), mk(0, -1, 0, 0, 0), mk(1, 0, 0, 0, 0),
             mk(0, 0, 29'h04000000, 0, 0), mk(0, 0, 29'h04000000, 0, 0),
             mk(0, 60, 0, 0, 0), mk(0, -60, 0, 0, 0), mk(1, 60, 0, 0, 0),
             mk(0, 0, 0, 1, 1), mk(1, 5, 0, 0, 1), mk(0, 48, 0, 0, 0), mk(0, -48, 0, 0, 0),
             mk(0, 49, 0, 0, 0), mk(0, -49, 0, 0, 0), mk(0, 8, 0, 0, 0), mk(0, -41, 0, 0, 0),
             mk(0, 0, 29'h0C000000, 0, 0), mk(1, -1, 0, 0, 0), mk(1, 0, 0, 1, 0)};
      vt = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      ve = '{8'h40, 8'h3C, 8'hC0, 8'h40, 8'h41, 8'h7F, 8'h01, 8'h81, 8'h80, 8'h00,
             8'h7F, 8'h01, 8'h7F, 8'h01, 8'h60, 8'h02, 8'h42, 8'hC4, 8'h80};
      for (int i = 0; i < 19; i++) begin
         xfer(vs[i], vt[i], p, lat);
         n_chk++;
         if (p !== ve[i]) begin n_fail++; $display("FAIL vec%0d posit got %h exp %h", i, p, ve[i]); end
         n_chk++;
         if (lat != 3) begin n_fail++; $display("FAIL vec%0d latency got %0d exp 3", i, lat); end
      end
   endtask

   task automatic test_back_to_back;
      logic [40:0] s [6];
      logic [7:0]  e [6];
      int          acc = 0, emit = 0, first_block = -1;
      logic        prev_stall = 1'b0;
      logic [7:0]  prev_p = 8'h00;
      s = '{mk(0, 0, 0, 0, 0), mk(0, -1, 0, 0, 0), mk(0, 8, 0, 0, 0),
            mk(0, 60, 0, 0, 0), mk(0, -60, 0, 0, 0), mk(1, 0, 0, 0, 0)};
      e = '{8'h40, 8'h3C, 8'h60, 8'h7F, 8'h01, 8'hC0};
      bus.in_truncated = 1'b0;
      for (int c = 1; c <= 40 && emit < 6; c++) begin
         @(posedge clk); #1;
         bus.out_ready = !(c >= 2 && c <= 6);
         bus.in_valid  = acc < 6;
         bus.in_sum    = acc < 6 ? s[acc] : '0;
         @(negedge clk);
         if (prev_stall) begin
            n_chk++;
            if (bus.out_valid !== 1'b1 || bus.out_posit !== prev_p) begin
               n_fail++;
               $display("FAIL b2b_stall_stable cycle %0d got v=%b p=%h exp v=1 p=%h", c, bus.out_valid, bus.out_posit, prev_p);
            end
         end
         if (bus.in_ready !== 1'b1 && first_block < 0) first_block = acc;
         if (bus.in_valid && bus.in_ready === 1'b1) acc++;
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            n_chk++;
            if (bus.out_posit !== e[emit]) begin n_fail++; $display("FAIL b2b_item%0d got %h exp %h", emit, bus.out_posit, e[emit]); end
            emit++;
         end
         prev_stall = bus.out_valid === 1'b1 && !bus.out_ready;
         prev_p = bus.out_posit;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      n_chk++;
      if (first_block != 3) begin n_fail++; $display("FAIL b2b_accept_before_block got %0d exp 3", first_block); end
      n_chk++;
      if (emit != 6) begin n_fail++; $display("FAIL b2b_emitted got %0d exp 6", emit); end
   endtask

   task automatic test_reset_midstream;
      int seen = 0;
      logic got_v = 1'b0;
      @(posedge clk); #1;
      bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_truncated = 1'b0; bus.in_sum = mk(0, 0, 0, 0, 0);
      @(posedge clk); #1;
      bus.in_sum = mk(0, 8, 0, 0, 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin got_v = 1'b1; break; end
      end
      n_chk++;
      if (got_v !== 1'b1) begin n_fail++; $display("FAIL midrst_precondition got out_valid %b exp 1", got_v); end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b exp 0", bus.out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) seen++;
      end
      n_chk++;
      if (seen != 0) begin n_fail++; $display("FAIL midrst_emitted_after got %0d exp 0", seen); end
      n_chk++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b exp 1", bus.in_ready); end
   endtask

   initial begin
      test_reset;
      test_vectors;
      test_back_to_back;
      test_reset_midstream;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
